// File: rtl/trng_postproc.sv
// trng_postproc: samples an asynchronous raw TRNG bit, applies Von Neumann debiasing and a
// repetition-count health test, and packs the debiased bits into words behind a valid/ready register.
module trng_postproc #(
    parameter int SAMPLE_DIV = 16,
    parameter int WORD_W     = 32,
    parameter int RCT_CUTOFF = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iEn,
    input  logic              iRawBit,
    input  logic              iReady,
    input  logic              iClrErr,
    output logic [WORD_W-1:0] oData,
    output logic              oValid,
    output logic              oHealthErr
);
    localparam int BW = $clog2(WORD_W + 1);

    logic [1:0]        sync_q, sync_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              pend_q, pend_d, first_q, first_d, prev_q, prev_d;
    logic [7:0]        rct_q, rct_d, rct_t;
    logic [WORD_W-1:0] shreg_q, shreg_d, data_q, data_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              valid_q, valid_d, err_q, err_d;
    logic              s, tick, emit, keep, full, xfer;

    always_comb begin
        s        = sync_q[1];
        tick     = iEn && cnt_q == 16'(SAMPLE_DIV - 1);
        sync_d   = {sync_q[0], iRawBit};
        cnt_d    = (!iEn || tick) ? 16'd0 : cnt_q + 16'd1;
        pend_d   = iEn && (tick ? !pend_q : pend_q);
        first_d  = (tick && !pend_q) ? s : first_q;
        emit     = tick && pend_q && (first_q != s);
        prev_d   = tick ? s : prev_q;
        // rct_q==0 marks "no sample seen since reset", so the first tick starts a fresh run
        rct_t    = !tick ? rct_q :
                   (rct_q == 8'd0 || s != prev_q) ? 8'd1 :
                   (rct_q == 8'(RCT_CUTOFF)) ? rct_q : rct_q + 8'd1;
        rct_d    = iClrErr ? 8'd1 : rct_t;
        err_d    = (tick && rct_t == 8'(RCT_CUTOFF)) || (err_q && !iClrErr);
        keep     = emit && !err_q;
        full     = bcnt_q == BW'(WORD_W);
        xfer     = full && (!valid_q || iReady);
        // a bit arriving with the transfer becomes bit 0 of the next word
        shreg_d  = (keep && (!full || xfer)) ? {shreg_q[WORD_W-2:0], first_q} : shreg_q;
        bcnt_d   = xfer ? BW'(keep) : (keep && !full) ? bcnt_q + BW'(1) : bcnt_q;
        data_d   = xfer ? shreg_q : data_q;
        valid_d  = xfer || (valid_q && !iReady);
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            prev_q  <= 1'b0;
            rct_q   <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            prev_q  <= prev_d;
            rct_q   <= rct_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign oData      = data_q;
    assign oValid     = valid_q;
    assign oHealthErr = err_q;
endmodule
